ram8_ctrl: RTL and testbench
============================

# ram8_ctrl

Request/response initiator that owns the port of one `RAM8` (8 × 16-bit words, write-enable, clocked write, read data = word at current address). Upstream logic issues read, write or clear-all commands over a valid/ready handshake. The block sequences the RAM8 signals and returns one response per accepted command. It replaces ad-hoc direct driving of `in`/`addr`/`write` and provides the memory-zeroing sequence in hardware.

## Interface
- `CLEAR_VALUE`, 16'h0000, word written to every address by a clear command.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  1  command present.
- `req_ready`  out  1  block can accept a command.
- `req_op`  in  2  00 read, 01 write, 10 clear-all, 11 reserved.
- `req_addr`  in  3  word address (read/write).
- `req_wdata`  in  16  write data.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer takes response.
- `rsp_data`  out  16  read data / written data / CLEAR_VALUE.
- `rsp_err`  out  1  1 = reserved op, no memory access made.
- `mem_in`  out  16  to RAM8 `in`.
- `mem_addr`  out  3  to RAM8 `addr`.
- `mem_write`  out  1  to RAM8 `write`.
- `mem_out`  in  16  from RAM8 `out`.

## Operation
- FSM states: IDLE, ACCESS, CLEAR, RESP.
- IDLE: `req_ready`=1. When `req_valid`&`req_ready` at an edge, latch op/addr/wdata. op 00/01/11 → ACCESS. op 10 → CLEAR with counter=0.
- ACCESS (1 cycle): `mem_addr`=latched addr, `mem_in`=latched wdata, `mem_write`=1 only for op 01. At the closing edge: read loads `rsp_data`←`mem_out`; write loads `rsp_data`←wdata; op 11 loads `rsp_data`←0 and `rsp_err`←1. → RESP.
- CLEAR (8 cycles): `mem_addr`=counter, `mem_in`=CLEAR_VALUE, `mem_write`=1. Counter increments each edge. Leaving after counter=7: `rsp_data`←CLEAR_VALUE, `rsp_err`←0, → RESP. The counter is 3 bits; wrap from 7 is the exit condition and must not cause a 9th write.
- RESP: `rsp_valid`=1; `rsp_data`/`rsp_err` held stable. When `rsp_valid`&`rsp_ready` at an edge → IDLE.
- `req_ready`=1 only in IDLE. Requests in other states are not accepted and must be held by the source.
- `mem_write`=0 in IDLE and RESP. Gate `mem_write` combinationally with `~reset` so no write reaches the RAM in any cycle where `reset`=1.
- `mem_addr`/`mem_in` hold their last driven values in IDLE/RESP.
- Outputs are registered or decoded from the state only. There is no combinational path from `req_*` to `mem_*`.

## Timing
- Reset values (after the edge with `reset`=1): state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0, `mem_addr`=0, `mem_in`=0, `mem_write`=0, counter=0.
- Read/write: accept at edge T. The ACCESS cycle is T→T+1, with the RAM write committed at edge T+1. `rsp_valid`=1 from T+1. Minimum command-to-command spacing is 3 cycles (accept, access, response with `rsp_ready`=1).
- Read after write to the same address returns the new data, since the write commits before the read's ACCESS cycle.
- Clear: accept at T. Writes to addr 0..7 commit at edges T+1..T+8. `rsp_valid` from T+8.
- Backpressure: `rsp_ready`=0 keeps RESP indefinitely. `req_ready` stays 0 and no memory activity occurs.
- Reset mid-operation: ACCESS/CLEAR/RESP abort to IDLE and any pending response is dropped. Words already written keep their new values. A write in the reset cycle itself is suppressed.
- `reset` and `req_valid` asserted together: the request is not accepted.

## Test plan
- Reset, clear (op 10): `mem_write`=1 for exactly 8 cycles with `mem_addr` 0..7 and `mem_in`=0000. `rsp_valid` follows with `rsp_data`=0000 and `rsp_err`=0. Reading each address then returns 0000.
- Write 0070,0065,0063,0075,006C,0069,0061,0072 to addr 0..7. Each response echoes its data. Reads of 0..7 return the same values in order.
- Write 1234 to addr 3, immediately read addr 3 → `rsp_data`=1234. Read addr 4 → its previous value, unchanged.
- Hold `rsp_ready`=0 for 5 cycles after a read of addr 0: `rsp_valid`/`rsp_data` stay stable, `req_ready`=0, a pending write to addr 1 is not applied, and the write is accepted only after the response is taken.
- op 11 at addr 2: `rsp_err`=1, `rsp_data`=0000, `mem_write` never asserted, addr 2 contents unchanged.
- Preload all words with FFFF, start a clear, assert `reset` after 3 writes committed: addr 0..2 = 0000, addr 3..7 = FFFF, no `rsp_valid`, `req_ready`=1 after reset.

Source files
------------

// File: rtl/ram8_ctrl.sv
// ram8_ctrl: request/response controller that owns the port of one RAM8
// (8 x 16-bit words, clocked write, combinational read of the addressed word).
//
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   req_valid/req_ready   command handshake; req_op 00 read, 01 write,
//                         10 clear-all, 11 reserved; req_addr, req_wdata
//   rsp_valid/rsp_ready   response handshake; rsp_data, rsp_err
//   mem_in, mem_addr,     drive RAM8 in/addr/write
//   mem_write
//   mem_out               RAM8 read data
//
// Each accepted command produces exactly one response. A clear writes
// CLEAR_VALUE to addresses 0..7 over eight consecutive cycles.
module ram8_ctrl #(
    parameter logic [15:0] CLEAR_VALUE = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [2:0]  req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    output logic [15:0] mem_in,
    output logic [2:0]  mem_addr,
    output logic        mem_write,
    input  logic [15:0] mem_out
);

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;

    typedef enum logic [1:0] {StIdle, StAccess, StClear, StResp} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [1:0]  r_op;
    logic [2:0]  r_cnt;
    logic [2:0]  r_mem_addr;
    logic [15:0] r_mem_in;
    logic [15:0] r_rsp_data;
    logic        r_rsp_err;
    logic        w_write_raw;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (req_valid) begin
                    w_state_next = (req_op == OP_CLEAR) ? StClear : StAccess;
                end
            end
            StAccess: w_state_next = StResp;
            // Exit on the last address so the 3-bit wrap never yields a 9th write.
            StClear: begin
                if (r_cnt == 3'd7) begin
                    w_state_next = StResp;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Outputs: decoded from state or taken straight from registers
    always_comb begin
        req_ready   = (r_state == StIdle);
        rsp_valid   = (r_state == StResp);
        w_write_raw = ((r_state == StAccess) && (r_op == OP_WRITE)) || (r_state == StClear);
        // Reset gates the strobe so an aborted sequence cannot write in the reset cycle.
        mem_write   = w_write_raw & ~reset;
        mem_addr    = r_mem_addr;
        mem_in      = r_mem_in;
        rsp_data    = r_rsp_data;
        rsp_err     = r_rsp_err;
    end

    // Datapath registers: latched command, clear counter, memory drive, response
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op       <= OP_READ;
            r_cnt      <= 3'd0;
            r_mem_addr <= 3'd0;
            r_mem_in   <= 16'h0000;
            r_rsp_data <= 16'h0000;
            r_rsp_err  <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (req_valid) begin
                        r_op <= req_op;
                        if (req_op == OP_CLEAR) begin
                            r_cnt      <= 3'd0;
                            r_mem_addr <= 3'd0;
                            r_mem_in   <= CLEAR_VALUE;
                        end else begin
                            r_mem_addr <= req_addr;
                            r_mem_in   <= req_wdata;
                        end
                    end
                end
                StAccess: begin
                    case (r_op)
                        OP_READ: begin
                            r_rsp_data <= mem_out;
                            r_rsp_err  <= 1'b0;
                        end
                        OP_WRITE: begin
                            r_rsp_data <= r_mem_in;
                            r_rsp_err  <= 1'b0;
                        end
                        default: begin
                            r_rsp_data <= 16'h0000;
                            r_rsp_err  <= 1'b1;
                        end
                    endcase
                end
                StClear: begin
                    r_cnt <= r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        // Leave mem_addr at 7 so it holds its last driven value.
                        r_rsp_data <= CLEAR_VALUE;
                        r_rsp_err  <= 1'b0;
                    end else begin
                        r_mem_addr <= r_cnt + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ram8_ctrl.sv
// Directed testbench for ram8_ctrl with a behavioural RAM8 model.
module tb_ram8_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [2:0]  req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic [15:0] mem_in;
    logic [2:0]  mem_addr;
    logic        mem_write;
    logic [15:0] mem_out;

    always #5 clk = ~clk;

    ram8_ctrl #(.CLEAR_VALUE(16'h0000)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .mem_in    (mem_in),
        .mem_addr  (mem_addr),
        .mem_write (mem_write),
        .mem_out   (mem_out)
    );

    // RAM8 model
    logic [15:0] mem [8];
    assign mem_out = mem[mem_addr];

    int          n_checks = 0;
    int          n_errors = 0;
    int          wr_cnt   = 0;
    int          rst_wr   = 0;
    logic [2:0]  log_addr [$];
    logic [15:0] log_data [$];

    always @(posedge clk) begin
        if (mem_write) begin
            mem[mem_addr] <= mem_in;
            wr_cnt++;
            log_addr.push_back(mem_addr);
            log_data.push_back(mem_in);
            if (reset) rst_wr++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_req(input logic [1:0] op, input logic [2:0] addr, input logic [15:0] wd);
        int i = 0;
        while (!req_ready && i < 50) begin
            @(negedge clk);
            i++;
        end
        if (!req_ready) check_eq("req_ready_timeout", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // lat counts negedges from the call until rsp_valid is seen.
    task automatic get_rsp(output logic [15:0] d, output logic e, output int lat);
        lat = 0;
        rsp_ready = 1'b1;
        while (!rsp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid) check_eq("rsp_timeout", {31'd0, rsp_valid}, 32'd1);
        d = rsp_data;
        e = rsp_err;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic wr(input logic [2:0] addr, input logic [15:0] wd);
        logic [15:0] d;
        logic        e;
        int          lat;
        send_req(2'b01, addr, wd);
        get_rsp(d, e, lat);
        check_eq($sformatf("wr_echo_a%0d", addr), {16'd0, d}, {16'd0, wd});
        check_eq($sformatf("wr_err_a%0d", addr), {31'd0, e}, 32'd0);
    endtask

    task automatic rd(input logic [2:0] addr, input logic [15:0] exp);
        logic [15:0] d;
        logic        e;
        int          lat;
        send_req(2'b00, addr, 16'h0000);
        get_rsp(d, e, lat);
        check_eq($sformatf("rd_data_a%0d", addr), {16'd0, d}, {16'd0, exp});
        check_eq($sformatf("rd_lat_a%0d", addr), lat, 32'd1);
    endtask

    logic [15:0] wvals [8];
    logic [15:0] d;
    logic        e;
    int          lat;
    int          w0;
    int          seen_valid;

    initial begin
        wvals = '{16'h0070, 16'h0065, 16'h0063, 16'h0075,
                  16'h006C, 16'h0069, 16'h0061, 16'h0072};
        for (int i = 0; i < 8; i++) mem[i] = 16'h5A50 + 16'(i);
        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_addr  = 3'd0;
        req_wdata = 16'h0000;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check_eq("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("rst_rsp_data", {16'd0, rsp_data}, 32'd0);
        check_eq("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        check_eq("rst_mem_addr", {29'd0, mem_addr}, 32'd0);
        check_eq("rst_mem_in", {16'd0, mem_in}, 32'd0);
        check_eq("rst_mem_write", {31'd0, mem_write}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Clear: exactly eight writes, addresses 0..7, value 0000
        log_addr.delete();
        log_data.delete();
        w0 = wr_cnt;
        send_req(2'b10, 3'd0, 16'hFFFF);
        get_rsp(d, e, lat);
        check_eq("clr_rsp_data", {16'd0, d}, 32'd0);
        check_eq("clr_rsp_err", {31'd0, e}, 32'd0);
        check_eq("clr_lat", lat, 32'd8);
        check_eq("clr_wr_count", wr_cnt - w0, 32'd8);
        for (int i = 0; i < 8 && i < log_addr.size(); i++) begin
            check_eq($sformatf("clr_addr%0d", i), {29'd0, log_addr[i]}, i);
            check_eq($sformatf("clr_data%0d", i), {16'd0, log_data[i]}, 32'd0);
        end
        for (int i = 0; i < 8; i++) rd(3'(i), 16'h0000);

        // Write pattern then read back in order
        for (int i = 0; i < 8; i++) wr(3'(i), wvals[i]);
        for (int i = 0; i < 8; i++) rd(3'(i), wvals[i]);

        // Read-after-write and untouched neighbour
        wr(3'd3, 16'h1234);
        rd(3'd3, 16'h1234);
        rd(3'd4, 16'h006C);

        // Backpressure: read addr 0 held in RESP while a write to addr 1 waits
        req_valid = 1'b1;
        req_op    = 2'b00;
        req_addr  = 3'd0;
        @(posedge clk);
        @(negedge clk);
        req_op    = 2'b01;
        req_addr  = 3'd1;
        req_wdata = 16'hBEEF;
        @(negedge clk);
        w0 = wr_cnt;
        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("bp_valid%0d", i), {31'd0, rsp_valid}, 32'd1);
            check_eq($sformatf("bp_data%0d", i), {16'd0, rsp_data}, 32'h0070);
            check_eq($sformatf("bp_ready%0d", i), {31'd0, req_ready}, 32'd0);
            @(negedge clk);
        end
        check_eq("bp_no_write", wr_cnt - w0, 32'd0);
        check_eq("bp_mem1_held", {16'd0, mem[1]}, 32'h0065);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check_eq("bp_idle_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        get_rsp(d, e, lat);
        check_eq("bp_wr_echo", {16'd0, d}, 32'hBEEF);
        check_eq("bp_mem1_new", {16'd0, mem[1]}, 32'hBEEF);

        // Reserved op
        w0 = wr_cnt;
        send_req(2'b11, 3'd2, 16'hAAAA);
        get_rsp(d, e, lat);
        check_eq("rsv_err", {31'd0, e}, 32'd1);
        check_eq("rsv_data", {16'd0, d}, 32'd0);
        check_eq("rsv_no_write", wr_cnt - w0, 32'd0);
        rd(3'd2, 16'h0063);

        // Request together with reset is not accepted
        w0 = wr_cnt;
        reset     = 1'b1;
        req_valid = 1'b1;
        req_op    = 2'b01;
        req_addr  = 3'd5;
        req_wdata = 16'hDEAD;
        @(negedge clk);
        reset     = 1'b0;
        req_valid = 1'b0;
        check_eq("rstreq_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        check_eq("rstreq_no_write", wr_cnt - w0, 32'd0);

        // Clear aborted by reset after three committed writes
        for (int i = 0; i < 8; i++) wr(3'(i), 16'hFFFF);
        send_req(2'b10, 3'd0, 16'h0000);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("abort_req_ready", {31'd0, req_ready}, 32'd1);
        seen_valid = 0;
        rsp_ready  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid) seen_valid++;
            @(negedge clk);
        end
        check_eq("abort_no_rsp", seen_valid, 32'd0);
        for (int i = 0; i < 8; i++)
            check_eq($sformatf("abort_mem%0d", i), {16'd0, mem[i]},
                     (i < 3) ? 32'h0000 : 32'hFFFF);
        rd(3'd2, 16'h0000);
        rd(3'd3, 16'hFFFF);

        check_eq("no_write_in_reset", rst_wr, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
